// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotating column strobe, synchronised and
// debounced row readback, one key code per press on a valid/ready handshake.
// Optional auto-repeat of the held key is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_BIT       = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED
  } state_t;

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic [SCAN_BIT-1:0] dwell;
  logic [1:0]          col_idx;
  logic [1:0]          col_next;
  logic                sample;
  logic [3:0]          row_meta;
  logic [3:0]          row_sync;

  assign sample   = &dwell;
  assign col_next = col_idx + 2'd1;

  // Column strobe: col_n is registered together with the index so the pins never glitch.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses <=, so every flop samples pre-edge values and
    // the order of statements inside the block cannot change the result.
    if (rst) begin
      dwell   <= '0;
      col_idx <= 2'd0;
      col_n   <= 4'b1110;
    end else begin
      dwell <= dwell + 1'b1;
      if (sample) begin
        col_idx <= col_next;
        col_n   <= ~(4'b0001 << col_next);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Lowest-index low row wins when several keys share the strobed column.
  logic       any_low;
  logic [1:0] win_row;

  assign any_low = ~&row_sync;

  always_comb begin
    win_row = 2'd0;
    if      (!row_sync[0]) win_row = 2'd0;
    else if (!row_sync[1]) win_row = 2'd1;
    else if (!row_sync[2]) win_row = 2'd2;
    else if (!row_sync[3]) win_row = 2'd3;
  end

  state_t     state, state_d;
  logic [1:0] lat_row, lat_row_d;
  logic [1:0] lat_col, lat_col_d;
  logic [3:0] agree_cnt, agree_d, agree_inc;
  logic [3:0] rel_cnt, rel_d, rel_inc;
  logic       at_lat_col;
  logic       press_issue;
  logic       issue;
  logic [3:0] issue_code;

  assign at_lat_col = sample && (col_idx == lat_col);
  assign agree_inc  = agree_cnt + 4'd1;
  assign rel_inc    = rel_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      agree_cnt <= 4'd0;
      rel_cnt   <= 4'd0;
    end else begin
      state     <= state_d;
      lat_row   <= lat_row_d;
      lat_col   <= lat_col_d;
      agree_cnt <= agree_d;
      rel_cnt   <= rel_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skipped an
    // assignment would otherwise infer a latch.
    state_d     = state;
    lat_row_d   = lat_row;
    lat_col_d   = lat_col;
    agree_d     = agree_cnt;
    rel_d       = rel_cnt;
    press_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample && any_low) begin
          lat_row_d = win_row;
          lat_col_d = col_idx;
          agree_d   = 4'd1;
          rel_d     = 4'd0;
          if (DB_TARGET == 4'd1) begin
            state_d     = PRESSED;
            press_issue = 1'b1;
          end else begin
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (at_lat_col) begin
          if (any_low && (win_row == lat_row)) begin
            agree_d = agree_inc;
            if (agree_inc == DB_TARGET) begin
              state_d     = PRESSED;
              press_issue = 1'b1;
              rel_d       = 4'd0;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      PRESSED: begin
        // Other columns and rows are ignored until the latched key is released.
        if (at_lat_col) begin
          if (!row_sync[lat_row]) begin
            rel_d = 4'd0;
          end else begin
            rel_d = rel_inc;
            if (rel_inc == DB_TARGET) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_code = {lat_row_d, lat_col_d};
  assign key_held   = (state == PRESSED);

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0] rep_cnt;
  logic          scan_wrap;
  logic          rep_fire;

  assign scan_wrap = sample && (col_idx == 2'd3);
  assign rep_fire  = (state == PRESSED) && (state_d == PRESSED) && scan_wrap &&
                     (rep_cnt == RW'(REPEAT_SCANS - 1));

  // Held at zero outside PRESSED, so a wrap on the entry edge is not counted.
  always_ff @(posedge clk) begin
    if (rst || (state != PRESSED)) begin
      rep_cnt <= '0;
    end else if (scan_wrap) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end

  assign issue = press_issue | rep_fire;
`else
  assign issue = press_issue;
`endif

  // A new code loads only into an empty or simultaneously-consumed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else if (issue && (!key_valid || key_ready)) begin
      key_code  <= issue_code;
      key_valid <= 1'b1;
    end else if (key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule
